// File: rtl/win_scan_seq.sv
// win_scan_seq: walks a WINDOW_SIZE x WINDOW_SIZE window over a square image
// and emits one (ptr, ptc, pt_bias) tap per accepted handshake, feeding the
// window address calculator with an absolute base address for every tap.
// Optional macro WIN_SCAN_TAP_CNT_EN adds a 16-bit accepted-tap counter port.
module win_scan_seq #(
    parameter int WINDOW_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] base_addr,
    input  logic [5:0]  img_edge,
    input  logic        pt_ready,
    output logic        pt_valid,
    output logic [5:0]  ptr,
    output logic [5:0]  ptc,
    output logic [3:0]  pt_bias,
    output logic [27:0] init_addr,
    output logic        init_addr_en,
    output logic        busy,
`ifdef WIN_SCAN_TAP_CNT_EN
    output logic [15:0] tap_cnt,
`endif
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [6:0] WIN7      = 7'(WINDOW_SIZE);
    localparam logic [6:0] STRIDE7   = 7'(STRIDE);
    localparam logic [3:0] LAST_BIAS = 4'(WINDOW_SIZE * WINDOW_SIZE - 1);

    logic [1:0] state;
    logic [5:0] edge_q;
    logic [6:0] last_org;
    logic [6:0] ptc_step;
    logic [6:0] ptr_step;
    logic       short_img;
    logic       accept;

    // Highest legal origin; only used in SCAN where it is known non-negative.
    // 7-bit intermediates keep origin+STRIDE from wrapping past 63.
    assign last_org     = {1'b0, edge_q} + 7'd1 - WIN7;
    assign ptc_step     = {1'b0, ptc} + STRIDE7;
    assign ptr_step     = {1'b0, ptr} + STRIDE7;
    assign short_img    = ({1'b0, img_edge} + 7'd1) < WIN7;
    assign accept       = pt_valid & pt_ready;
    assign init_addr_en = pt_valid;

    // Scan sequencer: capture on start, advance bias/column/row on each accept,
    // and finish with a single done pulse that drops busy on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            edge_q    <= '0;
            pt_valid  <= 1'b0;
            ptr       <= '0;
            ptc       <= '0;
            pt_bias   <= '0;
            init_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WIN_SCAN_TAP_CNT_EN
            tap_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        init_addr <= base_addr;
                        edge_q    <= img_edge;
                        busy      <= 1'b1;
                        ptr       <= '0;
                        ptc       <= '0;
                        pt_bias   <= '0;
`ifdef WIN_SCAN_TAP_CNT_EN
                        tap_cnt   <= '0;
`endif
                        if (short_img) begin
                            state <= FIN;
                        end else begin
                            state    <= SCAN;
                            pt_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (accept) begin
`ifdef WIN_SCAN_TAP_CNT_EN
                        tap_cnt <= tap_cnt + 16'd1;
`endif
                        if (pt_bias != LAST_BIAS) begin
                            pt_bias <= pt_bias + 4'd1;
                        end else begin
                            pt_bias <= '0;
                            if (ptc_step <= last_org) begin
                                ptc <= ptc_step[5:0];
                            end else begin
                                ptc <= '0;
                                if (ptr_step <= last_org) begin
                                    ptr <= ptr_step[5:0];
                                end else begin
                                    pt_valid <= 1'b0;
                                    busy     <= 1'b0;
                                    done     <= 1'b1;
                                    state    <= FIN;
                                end
                            end
                        end
                    end
                end
                FIN: begin
                    // Arriving from SCAN the done pulse is already up; an image
                    // too small for the window spends one busy cycle here first.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scan_seq.sv
// tb_win_scan_seq: drives two win_scan_seq instances (STRIDE 1 and STRIDE 2,
// WINDOW_SIZE 3) and compares their tap streams against a nested-loop model.
module tb_win_scan_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic        pt_ready;
    logic [27:0] base_addr;
    logic [5:0]  img_edge;
    logic        start_a, start_b;

    logic        a_valid, a_en, a_busy, a_done;
    logic [5:0]  a_ptr, a_ptc;
    logic [3:0]  a_bias;
    logic [27:0] a_init;
    logic        b_valid, b_en, b_busy, b_done;
    logic [5:0]  b_ptr, b_ptc;
    logic [3:0]  b_bias;
    logic [27:0] b_init;
`ifdef WIN_SCAN_TAP_CNT_EN
    logic [15:0] a_cnt, b_cnt, o_cnt;
    assign o_cnt = sel ? b_cnt : a_cnt;
`endif

    logic        o_valid, o_en, o_busy, o_done;
    logic [5:0]  o_ptr, o_ptc;
    logic [3:0]  o_bias;
    logic [27:0] o_init;

    int errors = 0;
    int checks = 0;

    // Free-running clock
    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_en    = sel ? b_en    : a_en;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_ptr   = sel ? b_ptr   : a_ptr;
    assign o_ptc   = sel ? b_ptc   : a_ptc;
    assign o_bias  = sel ? b_bias  : a_bias;
    assign o_init  = sel ? b_init  : a_init;

    win_scan_seq #(.WINDOW_SIZE(3), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .img_edge(img_edge), .pt_ready(pt_ready), .pt_valid(a_valid),
        .ptr(a_ptr), .ptc(a_ptc), .pt_bias(a_bias), .init_addr(a_init),
        .init_addr_en(a_en), .busy(a_busy),
`ifdef WIN_SCAN_TAP_CNT_EN
        .tap_cnt(a_cnt),
`endif
        .done(a_done)
    );

    win_scan_seq #(.WINDOW_SIZE(3), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .img_edge(img_edge), .pt_ready(pt_ready), .pt_valid(b_valid),
        .ptr(b_ptr), .ptc(b_ptc), .pt_bias(b_bias), .init_addr(b_init),
        .init_addr_en(b_en), .busy(b_busy),
`ifdef WIN_SCAN_TAP_CNT_EN
        .tap_cnt(b_cnt),
`endif
        .done(b_done)
    );

    function automatic logic [47:0] snap_out();
        return {o_valid, o_ptr, o_ptc, o_bias, o_init, o_en, o_busy, o_done};
    endfunction

    // Runs one full scan on the selected instance and checks every cycle.
    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic scan_check(input logic use_b, input logic [5:0] edge_v,
                              input logic [27:0] base_v, input int mode,
                              input string name);
        logic [15:0] exp_q[$];
        int stride, last_o, idx, cyc, last_acc, limit, exp_done;
        logic got_done, prev_stall, r;
        logic [47:0] prev, cur;
        stride = use_b ? 2 : 1;
        last_o = int'(edge_v) + 1 - 3;
        for (int row = 0; row <= last_o; row += stride)
            for (int col = 0; col <= last_o; col += stride)
                for (int b = 0; b < 9; b++)
                    exp_q.push_back({6'(row), 6'(col), 4'(b)});
        limit = exp_q.size() * 3 + 20;
        sel = use_b;
        @(negedge clk);
        start = 1'b1; base_addr = base_v; img_edge = edge_v; pt_ready = 1'b0;
        idx = 0; cyc = 0; last_acc = 0; got_done = 1'b0; prev_stall = 1'b0;
        prev = '0;
        while (!got_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            cur = snap_out();
            if (prev_stall) begin
                checks++;
                if (cur !== prev) begin
                    errors++;
                    $display("[TB] FAIL %s stall_hold cyc %0d: got %h expected %h", name, cyc, cur, prev);
                end
            end
            if (o_done) begin
                got_done = 1'b1;
                exp_done = (exp_q.size() == 0) ? 2 : last_acc + 1;
                checks++;
                if (idx != exp_q.size() || o_busy !== 1'b0 || o_valid !== 1'b0 || cyc != exp_done) begin
                    errors++;
                    $display("[TB] FAIL %s done: got taps=%0d busy=%b valid=%b cyc=%0d expected taps=%0d busy=0 valid=0 cyc=%0d",
                             name, idx, o_busy, o_valid, cyc, exp_q.size(), exp_done);
                end
            end else begin
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s busy cyc %0d: got %b expected 1", name, cyc, o_busy);
                end
                if (mode == 0 && idx < exp_q.size()) begin
                    checks++;
                    if (o_valid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL %s throughput cyc %0d: got valid=%b expected 1", name, cyc, o_valid);
                    end
                end
                if (o_valid === 1'b1) begin
                    checks++;
                    if (idx >= exp_q.size()) begin
                        errors++;
                        $display("[TB] FAIL %s extra_tap: got tap %0d expected only %0d taps", name, idx, exp_q.size());
                    end else if ({o_ptr, o_ptc, o_bias} !== exp_q[idx] || o_init !== base_v || o_en !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL %s tap %0d: got ptr=%0d ptc=%0d bias=%0d init=%h en=%b expected ptr=%0d ptc=%0d bias=%0d init=%h en=1",
                                 name, idx, o_ptr, o_ptc, o_bias, o_init, o_en,
                                 exp_q[idx][15:10], exp_q[idx][9:4], exp_q[idx][3:0], base_v);
                    end
                end
            end
            if (cyc == 3) base_addr = ~base_v;
            if (cyc == 4 && !got_done) begin start = 1'b1; img_edge = ~edge_v; end
            if (cyc == 5) start = 1'b0;
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
            else r = 1'($urandom % 2);
            pt_ready = r;
            if (o_valid === 1'b1 && r && !o_done) begin
                idx++;
                last_acc = cyc;
            end
            prev_stall = (o_valid === 1'b1) && !r && !o_done;
            prev = cur;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no done after %0d cycles expected done", name, cyc);
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s after_done: got busy=%b valid=%b done=%b expected 0 0 0", name, o_busy, o_valid, o_done);
            end
`ifdef WIN_SCAN_TAP_CNT_EN
            checks++;
            if (o_cnt !== 16'(exp_q.size())) begin
                errors++;
                $display("[TB] FAIL %s tap_cnt: got %0d expected %0d", name, o_cnt, exp_q.size());
            end
`endif
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s fin_start_ignored: got busy=%b valid=%b expected 0 0", name, o_busy, o_valid);
            end
        end
    endtask

    // Reset values on both instances
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pt_ready = 1'b0; sel = 1'b0;
        base_addr = '0; img_edge = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_valid, a_ptr, a_ptc, a_bias, a_init, a_en, a_busy, a_done} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_a: got %h expected 0", {a_valid, a_ptr, a_ptc, a_bias, a_init, a_en, a_busy, a_done});
        end
        checks++;
        if ({b_valid, b_ptr, b_ptc, b_bias, b_init, b_en, b_busy, b_done} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_b: got %h expected 0", {b_valid, b_ptr, b_ptc, b_bias, b_init, b_en, b_busy, b_done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        scan_check(1'b0, 6'd3, 28'h0000100, 0, "basic");
    endtask

    task automatic test_ready_toggle();
        scan_check(1'b0, 6'd3, 28'h0000100, 1, "ready_toggle");
    endtask

    task automatic test_stride2();
        scan_check(1'b1, 6'd6, 28'h0000100, 0, "stride2");
        scan_check(1'b1, 6'd63, 28'hABCDEF0, 0, "stride2_max_edge");
    endtask

    task automatic test_small_image();
        scan_check(1'b0, 6'd1, 28'h0000200, 0, "small_edge1");
        scan_check(1'b0, 6'd0, 28'h0000300, 0, "small_edge0");
        scan_check(1'b0, 6'd2, 28'h0000400, 0, "exact_fit");
    endtask

    // Reset while tap 10 is presented, then a fresh scan from the origin
    task automatic test_mid_reset();
        int acc = 0;
        logic [47:0] cur;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 28'h0000100; img_edge = 6'd3; pt_ready = 1'b1;
        for (int c = 0; c < 40 && acc < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (o_valid === 1'b1) acc++;
        end
        @(negedge clk);
        checks++;
        if ({o_ptr, o_ptc, o_bias} !== {6'd0, 6'd1, 4'd1} || o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_tap10: got valid=%b ptr=%0d ptc=%0d bias=%0d expected 1 0 1 1", o_valid, o_ptr, o_ptc, o_bias);
        end
        rst = 1'b1;
        @(negedge clk);
        cur = snap_out();
        checks++;
        if (cur !== 48'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0", cur);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done: got done=%b busy=%b expected 0 0", o_done, o_busy);
        end
        scan_check(1'b0, 6'd3, 28'h0000100, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            scan_check(1'($urandom % 2), 6'($urandom_range(0, 12)), 28'($urandom), 2, "random");
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_stride2();
        test_small_image();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/win_scan_seq.md
Name: win_scan_seq

Overview:
- Upstream sequencer for the window address calculator (comp_addr).
- Walks a square WINDOW_SIZE x WINDOW_SIZE convolution window across a square image of edge (img_edge+1) pixels.
- For every tap it emits a (ptr, ptc, pt_bias) triple plus init_addr/init_addr_en, so the calculator produces one DDR3 word address per tap.
- Start/done control handshake toward the layer controller; valid/ready handshake toward the address stage.

Parameters:
- WINDOW_SIZE, 3, window edge in pixels; legal values 2 or 3 (pt_bias range 0..WINDOW_SIZE^2-1).
- STRIDE, 1, window origin step in pixels, both row and column; legal values 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to scan one image; sampled only in IDLE.
- base_addr  in  28  image base DDR3 word address; captured on accepted start.
- img_edge  in  6  image edge minus 1; captured on accepted start.
- pt_ready  in  1  downstream accepts the current tap.
- pt_valid  out  1  ptr/ptc/pt_bias/init_addr describe a valid tap.
- ptr  out  6  window origin row.
- ptc  out  6  window origin column.
- pt_bias  out  4  tap index inside window, row-major (row = pt_bias / WINDOW_SIZE, col = pt_bias mod WINDOW_SIZE).
- init_addr  out  28  captured base_addr, held for the whole scan.
- init_addr_en  out  1  equals pt_valid, so every tap address is absolute (base + offset), never accumulated.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last tap is accepted.

Behaviour:
- Reset values: state IDLE; pt_valid, init_addr_en, busy, done = 0; ptr, ptc, pt_bias = 0; init_addr = 0.
- Derived limit LAST = img_edge + 1 - WINDOW_SIZE, computed 7-bit signed from the captured img_edge. Legal origins are 0..LAST in steps of STRIDE.
- FSM states IDLE, SCAN, FIN.
- IDLE: on start, capture base_addr and img_edge, set busy=1.
  - If img_edge+1 < WINDOW_SIZE: go to FIN with no taps emitted.
  - Otherwise go to SCAN with ptr=ptc=pt_bias=0 and pt_valid=1 on the next cycle (first tap visible 1 cycle after start).
- SCAN: a tap is consumed on a cycle where pt_valid & pt_ready. Advance order: pt_bias fastest, then ptc, then ptr.
  - pt_bias < WINDOW_SIZE^2-1: pt_bias+1.
  - Otherwise pt_bias=0 and, if ptc+STRIDE <= LAST, ptc += STRIDE.
  - Otherwise ptc=0 and, if ptr+STRIDE <= LAST, ptr += STRIDE.
  - Otherwise this was the last tap: pt_valid=0 and go to FIN.
- All comparisons use 7-bit intermediates so ptc+STRIDE cannot wrap at 63.
- Stall: while pt_valid & !pt_ready, every output is held bit-stable.
- FIN: done=1 for exactly one cycle, busy=0 on the same cycle, then IDLE. A start arriving during FIN is ignored.
- A start during SCAN is ignored; captured base_addr and img_edge do not change mid-scan.
- Throughput: one tap per cycle with pt_ready held high.
- Total taps = (floor(LAST/STRIDE)+1)^2 * WINDOW_SIZE^2.
- rst asserted mid-scan: return to reset values on the next edge, no done pulse.

Optional Feature:
- Macro WIN_SCAN_TAP_CNT_EN.
- Defined: adds output tap_cnt [15:0]. It clears on accepted start, increments on every accepted tap, holds its value after done for readback, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- WINDOW_SIZE=3, STRIDE=1, img_edge=3, pt_ready=1:
  - 36 taps on consecutive cycles, first (0,0,0) one cycle after start, last (1,1,8).
  - done one cycle after the last accept; with macro, tap_cnt=36.
- Same setup, pt_ready toggling 1,0,0,1 repeatedly: outputs stable during every low cycle, identical 36-tap sequence, no tap skipped or duplicated.
- STRIDE=2, img_edge=6: origins {0,2,4}^2, 81 taps. ptc wraps 4->0 while ptr increments; last tap (4,4,8).
- img_edge=1 with WINDOW_SIZE=3: no pt_valid ever, busy for 1 cycle, done pulse 2 cycles after start.
- start pulsed during SCAN and during FIN: ignored. base_addr change mid-scan: init_addr keeps the captured 0x0000100.
- rst=1 at tap 10: next cycle all outputs are 0, no done; a new start scans from (0,0,0).
